// File: rtl/difftest_debug_mode_arbiter.sv
// Round-robin arbiter that funnels per-core debug-CSR snapshots into one
// DifftestDebugMode probe through a single valid/ready output register.
module difftest_debug_mode_arbiter #(
  parameter int NCORE        = 4,
  parameter int CORE_ID_BASE = 0,
  parameter int DROP_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCORE-1:0]     io_in_valid,
  input  logic [NCORE*257-1:0] io_in_bits,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [7:0]           io_out_coreid,
  output logic                 io_out_debugMode,
  output logic [63:0]          io_out_dcsr,
  output logic [63:0]          io_out_dpc,
  output logic [63:0]          io_out_dscratch0,
  output logic [63:0]          io_out_dscratch1,
  output logic [DROP_W-1:0]    io_drop_count,
  output logic [NCORE-1:0]     io_pending
);

  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int CW = $clog2(NCORE + 1);
  localparam int SW = DROP_W + CW;

  logic [256:0]      slot [NCORE];
  logic [NCORE-1:0]  occ;
  logic [PW-1:0]     rr_ptr;
  logic              out_valid;
  logic [256:0]      out_data;
  logic [7:0]        out_coreid;
  logic [DROP_W-1:0] drop;

  logic              free;
  logic              take;
  logic              found;
  logic [31:0]       scan_idx;
  logic [PW-1:0]     grant_idx;
  logic [NCORE-1:0]  drain;
  logic [NCORE-1:0]  ovw;
  logic [CW-1:0]     ovw_cnt;
  logic [SW-1:0]     drop_sum;
  logic [DROP_W-1:0] drop_next;

  assign free = !out_valid || io_out_ready;
  assign take = free && (|occ);

  // First occupied slot after rr_ptr, wrapping modulo NCORE.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NCORE; k++) begin
      scan_idx = (32'(rr_ptr) + k) % NCORE;
      if (!found && occ[PW'(scan_idx)]) begin
        found     = 1'b1;
        grant_idx = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    drain   = '0;
    ovw     = '0;
    ovw_cnt = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      drain[i] = take && (grant_idx == PW'(i));
      ovw[i]   = io_in_valid[i] && occ[i] && !drain[i];
      ovw_cnt  = ovw_cnt + CW'(ovw[i]);
    end
    drop_sum  = SW'(drop) + SW'(ovw_cnt);
    drop_next = (drop_sum > SW'({DROP_W{1'b1}})) ? '1 : DROP_W'(drop_sum);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCORE; i++) slot[i] <= '0;
      occ        <= '0;
      rr_ptr     <= PW'(NCORE - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_coreid <= '0;
      drop       <= '0;
    end else begin
      // A same-edge drain reads the old slot value, so refill never counts as a drop.
      for (int unsigned i = 0; i < NCORE; i++) begin
        if (io_in_valid[i]) slot[i] <= io_in_bits[257*i +: 257];
        occ[i] <= io_in_valid[i] || (occ[i] && !drain[i]);
      end
      if (take) begin
        out_data   <= slot[grant_idx];
        out_valid  <= 1'b1;
        out_coreid <= 8'(CORE_ID_BASE) + 8'(grant_idx);
        rr_ptr     <= grant_idx;
      end else if (free) begin
        out_valid  <= 1'b0;
      end
      drop <= drop_next;
    end
  end

  assign io_out_valid     = out_valid;
  assign io_out_coreid    = out_coreid;
  assign io_out_debugMode = out_data[256];
  assign io_out_dcsr      = out_data[255:192];
  assign io_out_dpc       = out_data[191:128];
  assign io_out_dscratch0 = out_data[127:64];
  assign io_out_dscratch1 = out_data[63:0];
  assign io_drop_count    = drop;
  assign io_pending       = occ;

endmodule

// File: tb/tb_difftest_debug_mode_arbiter.sv
// Directed bench for difftest_debug_mode_arbiter; a second instance with
// DROP_W=2 and CORE_ID_BASE=254 shares the stimulus for saturation/truncation.
module tb_difftest_debug_mode_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic [3:0] in_valid;
  logic [4*257-1:0] in_bits;
  logic ready;

  logic out_valid, dm;
  logic [7:0] coreid;
  logic [63:0] dcsr, dpc, ds0, ds1;
  logic [15:0] drop;
  logic [3:0] pending;

  logic out_valid2, dm2;
  logic [7:0] coreid2;
  logic [63:0] dcsr2, dpc2, ds02, ds12;
  logic [1:0] drop2;
  logic [3:0] pending2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  difftest_debug_mode_arbiter #(.NCORE(4), .CORE_ID_BASE(0), .DROP_W(16)) dut (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_bits(in_bits),
    .io_out_valid(out_valid), .io_out_ready(ready), .io_out_coreid(coreid),
    .io_out_debugMode(dm), .io_out_dcsr(dcsr), .io_out_dpc(dpc),
    .io_out_dscratch0(ds0), .io_out_dscratch1(ds1),
    .io_drop_count(drop), .io_pending(pending));

  difftest_debug_mode_arbiter #(.NCORE(4), .CORE_ID_BASE(254), .DROP_W(2)) dut2 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_bits(in_bits),
    .io_out_valid(out_valid2), .io_out_ready(ready), .io_out_coreid(coreid2),
    .io_out_debugMode(dm2), .io_out_dcsr(dcsr2), .io_out_dpc(dpc2),
    .io_out_dscratch0(ds02), .io_out_dscratch1(ds12),
    .io_drop_count(drop2), .io_pending(pending2));

  function automatic logic [256:0] snap(input int core, input logic [63:0] d);
    return {1'b1, 64'hDC50_0000 + 64'(core), d, 64'hA000 + 64'(core), 64'hB000 + 64'(core)};
  endfunction

  task automatic post(input int core, input logic [63:0] d);
    in_valid[core] = 1'b1;
    in_bits[257*core +: 257] = snap(core, d);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = '0;
    ready = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = '0;
    in_bits = '0;
    ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
    checks++; if (drop !== 16'h0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop); end
    checks++; if (dpc !== 64'h0 || dcsr !== 64'h0 || dm !== 1'b0) begin errors++; $display("FAIL reset_data got dpc %h dcsr %h want 0", dpc, dcsr); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_single();
    apply_reset();
    ready = 1'b1;
    post(2, 64'h8000_0000);
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got %0b want 0", out_valid); end
    checks++; if (pending !== 4'h4) begin errors++; $display("FAIL single_pend got %h want 4", pending); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (coreid !== 8'd2) begin errors++; $display("FAIL single_coreid got %0d want 2", coreid); end
    checks++; if (dpc !== 64'h8000_0000) begin errors++; $display("FAIL single_dpc got %h want 80000000", dpc); end
    checks++; if (dcsr !== 64'hDC50_0002 || dm !== 1'b1 || ds0 !== 64'hA002 || ds1 !== 64'hB002) begin
      errors++; $display("FAIL single_fields got dm %0b dcsr %h ds0 %h ds1 %h", dm, dcsr, ds0, ds1); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL single_pend2 got %h want 0", pending); end
    checks++; if (coreid2 !== 8'h00) begin errors++; $display("FAIL single_coreid_wrap got %h want 00", coreid2); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_onebeat got %0b want 0", out_valid); end
    checks++; if (dpc !== 64'h8000_0000) begin errors++; $display("FAIL single_hold got %h want 80000000", dpc); end
  endtask

  task automatic test_all_cores();
    logic [3:0] exp_p;
    logic [7:0] exp_c2;
    apply_reset();
    ready = 1'b1;
    for (int c = 0; c < 4; c++) post(c, 64'h1000 + 64'(c));
    tick();
    in_valid = '0;
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL all_pend0 got %h want F", pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL all_valid0 got %0b want 0", out_valid); end
    exp_p = 4'hF;
    for (int g = 0; g < 4; g++) begin
      tick();
      exp_p = exp_p << 1;
      exp_c2 = 8'd254 + 8'(g);
      checks++; if (out_valid !== 1'b1 || coreid !== 8'(g)) begin errors++; $display("FAIL all_grant%0d got v %0b id %0d want 1 %0d", g, out_valid, coreid, g); end
      checks++; if (dpc !== 64'h1000 + 64'(g)) begin errors++; $display("FAIL all_dpc%0d got %h want %h", g, dpc, 64'h1000 + 64'(g)); end
      checks++; if (pending !== exp_p) begin errors++; $display("FAIL all_pend%0d got %h want %h", g + 1, pending, exp_p); end
      checks++; if (coreid2 !== exp_c2) begin errors++; $display("FAIL all_coreid2_%0d got %h want %h", g, coreid2, exp_c2); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL all_done got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready = 1'b0;
    post(0, 64'h2000);
    tick();
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || coreid !== 8'd0 || dpc !== 64'h2000) begin
      errors++; $display("FAIL bp_first got v %0b id %0d dpc %h want 1 0 2000", out_valid, coreid, dpc); end
    for (int c = 0; c < 10; c++) begin
      in_valid = '0;
      if (c == 1 || c == 3 || c == 5) post(1, 64'h3000 + 64'(c));
      tick();
      checks++; if (out_valid !== 1'b1 || coreid !== 8'd0 || dpc !== 64'h2000 || dcsr !== 64'hDC50_0000 || ds0 !== 64'hA000 || ds1 !== 64'hB000 || dm !== 1'b1) begin
        errors++; $display("FAIL bp_stable%0d got v %0b id %0d dpc %h dcsr %h", c, out_valid, coreid, dpc, dcsr); end
    end
    in_valid = '0;
    checks++; if (drop !== 16'd2) begin errors++; $display("FAIL bp_drop got %0d want 2", drop); end
    checks++; if (drop2 !== 2'd2) begin errors++; $display("FAIL bp_drop2 got %0d want 2", drop2); end
    checks++; if (pending !== 4'h2) begin errors++; $display("FAIL bp_pend got %h want 2", pending); end
    ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || coreid !== 8'd1 || dpc !== 64'h3005) begin
      errors++; $display("FAIL bp_last got v %0b id %0d dpc %h want 1 1 3005", out_valid, coreid, dpc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      post(0, 64'h4000 + 64'(c));
      tick();
      if (c == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_lat got %0b want 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1 || dpc !== 64'h4000 + 64'(c - 1)) begin
          errors++; $display("FAIL b2b_fwd%0d got v %0b dpc %h want 1 %h", c, out_valid, dpc, 64'h4000 + 64'(c - 1)); end
        checks++; if (pending !== 4'h1 || drop !== 16'd0) begin
          errors++; $display("FAIL b2b_state%0d got pend %h drop %0d want 1 0", c, pending, drop); end
      end
    end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || dpc !== 64'h4007 || pending !== 4'h0 || drop !== 16'd0) begin
      errors++; $display("FAIL b2b_tail got v %0b dpc %h pend %h drop %0d", out_valid, dpc, pending, drop); end
  endtask

  task automatic test_saturate();
    int exp_d;
    int exp_d2;
    apply_reset();
    ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      post(3, 64'h5000 + 64'(c));
      tick();
      exp_d = (c >= 2) ? c - 1 : 0;
      exp_d2 = (exp_d > 3) ? 3 : exp_d;
      checks++; if (drop !== 16'(exp_d)) begin errors++; $display("FAIL sat_drop%0d got %0d want %0d", c, drop, exp_d); end
      checks++; if (drop2 !== 2'(exp_d2)) begin errors++; $display("FAIL sat_drop2_%0d got %0d want %0d", c, drop2, exp_d2); end
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ready = 1'b0;
    for (int c = 0; c < 4; c++) post(c, 64'h6000 + 64'(c));
    tick();
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || pending !== 4'hE) begin
      errors++; $display("FAIL mid_pre got v %0b pend %h want 1 E", out_valid, pending); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || pending !== 4'h0) begin
      errors++; $display("FAIL mid_async got v %0b pend %h want 0 0", out_valid, pending); end
    checks++; if (dpc !== 64'h0 || coreid !== 8'h0) begin
      errors++; $display("FAIL mid_data got dpc %h id %0d want 0 0", dpc, coreid); end
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 4; c++) post(c, 64'h7000 + 64'(c));
    tick();
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || coreid !== 8'd0 || dpc !== 64'h7000) begin
      errors++; $display("FAIL mid_first got v %0b id %0d dpc %h want 1 0 7000", out_valid, coreid, dpc); end
    tick();
    checks++; if (coreid !== 8'd1 || dpc !== 64'h7001) begin
      errors++; $display("FAIL mid_second got id %0d dpc %h want 1 7001", coreid, dpc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_cores();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
